// File: rtl/ctrl.sv
// Main control decoder: maps the 6-bit opcode to the 14-bit datapath control word.
// Optional output register enabled by CTRL_REG_OUT_EN (1-cycle latency, sync reset).
module ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OP,
  output logic [13:0] signal,
  output logic        illegal
);

  // Field order: Membyte ALUOP SA SB[1:0] RegDst[1:0] Mem2Reg RegW MemR MemW PC_S PCWC PCW
  localparam logic [13:0] CW_RTYPE  = 14'h18A0;
  localparam logic [13:0] CW_J      = 14'h0001;
  localparam logic [13:0] CW_JAL    = 14'h0121;
  localparam logic [13:0] CW_BRANCH = 14'h0602;
  localparam logic [13:0] CW_IMM    = 14'h0C20;
  localparam logic [13:0] CW_COP0   = 14'h0820;
  localparam logic [13:0] CW_LW     = 14'h0C70;
  localparam logic [13:0] CW_LHU    = 14'h2C70;
  localparam logic [13:0] CW_SW     = 14'h0C08;
  localparam logic [13:0] CW_SH     = 14'h2C08;

  logic [13:0] signal_d;
  logic        illegal_d;

  always_comb begin
    signal_d  = 14'h0000;
    illegal_d = 1'b0;
    case (OP)
      6'h00:                      signal_d = CW_RTYPE;
      6'h02:                      signal_d = CW_J;
      6'h03:                      signal_d = CW_JAL;
      6'h04, 6'h05:               signal_d = CW_BRANCH;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: signal_d = CW_IMM;
      6'h10:                      signal_d = CW_COP0;
      6'h23:                      signal_d = CW_LW;
      6'h25:                      signal_d = CW_LHU;
      6'h2B:                      signal_d = CW_SW;
      6'h29:                      signal_d = CW_SH;
      // unknown opcodes decode to a no-op word so nothing gets written
      default:                    illegal_d = 1'b1;
    endcase
  end

`ifdef CTRL_REG_OUT_EN
  logic [13:0] signal_q;
  logic        illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      signal_q  <= 14'h0000;
      illegal_q <= 1'b0;
    end else begin
      signal_q  <= signal_d;
      illegal_q <= illegal_d;
    end
  end

  assign signal  = signal_q;
  assign illegal = illegal_q;
`else
  // clk/rst stay on the port list so both builds share one footprint
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign signal  = signal_d;
  assign illegal = illegal_d;
`endif

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl; expectations queued at drive time, popped when output is valid.
// Covers both the combinational build and the CTRL_REG_OUT_EN registered build.
module tb_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  OP;
  logic [13:0] signal;
  logic        illegal;

  int n_checks;
  int n_pass;
  logic [14:0] exp_q[$];

  ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .OP      (OP),
    .signal  (signal),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference decode: {illegal, control word}
  function automatic logic [14:0] ref_decode(input logic [5:0] op);
    case (op)
      6'h00: return {1'b0, 14'h18A0};
      6'h02: return {1'b0, 14'h0001};
      6'h03: return {1'b0, 14'h0121};
      6'h04: return {1'b0, 14'h0602};
      6'h05: return {1'b0, 14'h0602};
      6'h10: return {1'b0, 14'h0820};
      6'h23: return {1'b0, 14'h0C70};
      6'h25: return {1'b0, 14'h2C70};
      6'h2B: return {1'b0, 14'h0C08};
      6'h29: return {1'b0, 14'h2C08};
      default: begin
        if (op >= 6'h08 && op <= 6'h0F) return {1'b0, 14'h0C20};
        return {1'b1, 14'h0000};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // drive one opcode, queue its expected result, then compare once the DUT output is valid
  task automatic step(input logic [5:0] op, input logic rst_v, input string tag);
    logic [14:0] exp;
    OP  = op;
    rst = rst_v;
`ifdef CTRL_REG_OUT_EN
    exp = rst_v ? 15'h0000 : ref_decode(op);
`else
    exp = ref_decode(op);
`endif
    exp_q.push_back(exp);
`ifdef CTRL_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 15'h7FFF, 15'h0000);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {illegal, signal}, exp);
    end
  endtask

  // structural rules that must hold for any decoded word
  task automatic check_rules(input logic [5:0] op);
    logic b13_exp;
    b13_exp = (op == 6'h25) || (op == 6'h29);
    check("memr_memw_excl", {14'h0, signal[4] & signal[3]}, 15'h0);
    check("pcw_pcwc_excl",  {14'h0, signal[1] & signal[0]}, 15'h0);
    check("membyte_bit",    {14'h0, signal[13]}, {14'h0, b13_exp});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    OP  = 6'h00;
    #2;

`ifdef CTRL_REG_OUT_EN
    step(6'h00, 1'b1, "reset_hold");
    step(6'h00, 1'b0, "reset_release_rtype");
    #3;
    OP = 6'h0D;
    #1;
    check("op_change_between_edges", {illegal, signal}, {1'b0, 14'h18A0});
    step(6'h0D, 1'b0, "ori_after_edge");
    step(6'h02, 1'b0, "j_before_reset");
    step(6'h02, 1'b1, "reset_mid_op");
    step(6'h02, 1'b0, "j_after_reset");
`else
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step(6'h10, i[0], "cop0_clk_rst_toggle");
    end
    rst = 1'b0;
`endif

    for (int i = 0; i < 64; i++) begin
      step(i[5:0], 1'b0, $sformatf("sweep_op_%02h", i));
      check_rules(i[5:0]);
    end

    step(6'h23, 1'b0, "lw");
    check_rules(6'h23);
    step(6'h2B, 1'b0, "sw");
    check_rules(6'h2B);
    step(6'h25, 1'b0, "lhu");
    check_rules(6'h25);
    step(6'h03, 1'b0, "jal");
    check("jal_regdst", {13'h0, signal[8:7]}, 15'd2);
    step(6'h04, 1'b0, "beq");
    check("beq_sb", {13'h0, signal[10:9]}, 15'd3);
    check("beq_sa", {14'h0, signal[11]}, 15'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
